// File: rtl/inst_prefetch_buffer_pkg.sv
// Shared types for the instruction prefetch buffer.
// FSM encoding, NOP word and the default boot PC.
package inst_prefetch_buffer_pkg;

  typedef enum logic [1:0] {
    PF_IDLE    = 2'd0,
    PF_WAIT    = 2'd1,
    PF_DISCARD = 2'd2
  } pf_state_e;

  localparam logic [31:0] NOP_WORD     = 32'h0;
  localparam logic [31:0] RESET_PC_DEF = 32'h0;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc_plus4;
  } pf_entry_t;

endpackage

// File: rtl/inst_prefetch_buffer_fifo.sv
// pf_fifo: circular buffer of fetched words with flush.
// Pointers wrap naturally because DEPTH is a power of two.
module pf_fifo
  import inst_prefetch_buffer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push,
  input  logic      pop,
  input  logic      flush,
  input  pf_entry_t wdata,
  output pf_entry_t rdata,
  output logic      empty,
  output logic      full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  pf_entry_t     mem_q [DEPTH];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // storage needs no reset: reads are masked while empty
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));

endmodule

// File: rtl/inst_prefetch_buffer.sv
// Instruction prefetch buffer: one outstanding imem read,
// FIFO of {instr, pc+4} toward decode, redirect flush.
module inst_prefetch_buffer
  import inst_prefetch_buffer_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic [31:0] instr_out,
  output logic [31:0] pc_plus4_out,
  output logic        instr_valid
);

  pf_state_e   state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic        req_q, req_d;
  logic [31:0] addr_q, addr_d;

  logic      push, pop, empty, full;
  pf_entry_t wdata, head;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_d      = req_q;
    addr_d     = addr_q;
    push       = 1'b0;
    unique case (state_q)
      PF_IDLE: begin
        if (redirect) begin
          fetch_pc_d = redirect_pc;
        end else if (!full) begin
          req_d   = 1'b1;
          addr_d  = fetch_pc_q;
          state_d = PF_WAIT;
        end
      end
      PF_WAIT: begin
        if (redirect) begin
          fetch_pc_d = redirect_pc;
          if (imem_ack) begin
            req_d   = 1'b0;
            state_d = PF_IDLE;
          end else begin
            state_d = PF_DISCARD;
          end
        end else if (imem_ack) begin
          push       = 1'b1;
          fetch_pc_d = fetch_pc_q + 32'd4;
          req_d      = 1'b0;
          state_d    = PF_IDLE;
        end
      end
      PF_DISCARD: begin
        // request stays up; its data is thrown away
        if (redirect) fetch_pc_d = redirect_pc;
        if (imem_ack) begin
          req_d   = 1'b0;
          state_d = PF_IDLE;
        end
      end
      default: state_d = PF_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= PF_IDLE;
      fetch_pc_q <= RESET_PC;
      req_q      <= 1'b0;
      addr_q     <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
    end
  end

  assign wdata = '{instr: imem_rdata, pc_plus4: fetch_pc_q + 32'd4};
  assign pop   = !empty && !stall && !redirect;

  pf_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (reset),
    .push  (push),
    .pop   (pop),
    .flush (redirect),
    .wdata (wdata),
    .rdata (head),
    .empty (empty),
    .full  (full)
  );

  assign imem_req     = req_q;
  assign imem_addr    = addr_q;
  assign instr_valid  = !empty;
  assign instr_out    = empty ? NOP_WORD : head.instr;
  assign pc_plus4_out = empty ? 32'h0 : head.pc_plus4;

endmodule

// File: doc/inst_prefetch_buffer.md
INST_PREFETCH_BUFFER -- requirements
Module: inst_prefetch_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning FIFO entry count (power of two, 2..16).
REQ-002 SHALL have parameter RESET_PC, default 32'h0, meaning first fetch address.
REQ-003 SHALL have clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have imem_req  output  1  instruction-memory read request.
REQ-006 SHALL have imem_addr  output  32  word-aligned fetch address.
REQ-007 SHALL have imem_ack  input  1  one-cycle pulse; read data valid this cycle.
REQ-008 SHALL have imem_rdata  input  32  instruction word returned with imem_ack.
REQ-009 SHALL have redirect  input  1  branch/jump taken in decode (PCSrc nonzero).
REQ-010 SHALL have redirect_pc  input  32  new fetch address, sampled when redirect=1.
REQ-011 SHALL have stall  input  1  decode stall; head entry held.
REQ-012 SHALL have instr_out  output  32  head instruction to the decode register.
REQ-013 SHALL have pc_plus4_out  output  32  head instruction address + 4.
REQ-014 SHALL have instr_valid  output  1  head entry is valid.

Function
REQ-015 SHALL keep fetch_pc, FIFO of {instr, pc+4}, and FSM states IDLE, WAIT, DISCARD.
REQ-016 SHALL, in IDLE, register imem_req=1 and imem_addr=fetch_pc on the next edge when count<DEPTH and redirect=0, moving to WAIT.
REQ-017 SHALL hold imem_req and imem_addr stable in WAIT/DISCARD until imem_ack; at most one request outstanding.
REQ-018 SHALL, on imem_ack in WAIT without redirect, push {imem_rdata, fetch_pc+4}, set fetch_pc+=4, drop imem_req, return to IDLE; next request no earlier than the following cycle.
REQ-019 SHALL pop the head when instr_valid=1 and stall=0 and redirect=0.
REQ-020 SHALL keep count unchanged on simultaneous push and pop; push never occurs at count=DEPTH.
REQ-021 SHALL, on redirect, empty the FIFO, load fetch_pc=redirect_pc on that edge; redirect overrides any same-cycle pop or push.
REQ-022 SHALL, on redirect while in WAIT without imem_ack, go to DISCARD; the outstanding response is dropped on its ack, then IDLE.
REQ-023 SHALL, on redirect coinciding with imem_ack, drop the returned word and go to IDLE.
REQ-024 SHALL, on redirect while in DISCARD, update fetch_pc and remain in DISCARD.
REQ-025 SHALL drive instr_out=32'h0 (NOP) and pc_plus4_out=32'h0 when FIFO empty; instr_valid=(count!=0).
REQ-026 SHALL compute pointers modulo DEPTH (wrap-around) and fetch_pc+4 modulo 2^32.
REQ-027 SHALL present head data combinationally from FIFO storage; zero latency from push edge to instr_valid.

Reset
REQ-028 SHALL, while reset=0, force state=IDLE, fetch_pc=RESET_PC, count=0, pointers=0, imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr_out=0, pc_plus4_out=0.
REQ-029 SHALL abandon any outstanding request on reset mid-operation; an imem_ack arriving in IDLE after reset is ignored.
REQ-030 SHALL assert first imem_req on the first rising edge after reset deasserts.

Structure
REQ-031 SHALL place the FSM state encoding, NOP word and RESET_PC default in the shared CPU package.
REQ-032 SHALL instantiate one sub-module pf_fifo (storage, pointers, count, push/pop/flush).

Verification
REQ-033 Reset release, imem_ack 2 cycles after each req -> addresses 0,4,8,12 requested; instr_valid rises on first ack edge; pc_plus4_out=4 for first word.
REQ-034 stall=1 held, ack every cycle possible -> exactly 4 words buffered, imem_req stays 0 at count=4; release stall -> words exit in order 0,4,8,12.
REQ-035 redirect=1, redirect_pc=32'h40 with request to 8 outstanding -> FIFO empties same edge, ack for 8 dropped, next imem_addr=32'h40.
REQ-036 redirect coincident with imem_ack -> returned word never appears on instr_out; next request to redirect_pc the following cycle.
REQ-037 reset=0 asserted mid-WAIT, then late imem_ack -> all outputs at reset values, late ack ignored, fetch restarts at 32'h0.
REQ-038 Continuous stream of 10 words with no stall -> pointers wrap past DEPTH, output order and pc_plus4_out values (4..40) correct.
